// File: rtl/lut_sched.sv
// Round-robin sharing of one combinational byte-substitution LUT between two vector requesters.
// Latency: accept at edge T, one CHUNK_W beat per cycle, resp_valid from cycle T+NUM_BEATS+1.
// Backpressure: resp_ready low holds the response stable; no new grant until it is taken.
module lut_sched #(
  parameter int VEC_W     = 128,
  parameter int CHUNK_W   = 32,
  parameter int NUM_BEATS = VEC_W / CHUNK_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [VEC_W-1:0]   req0_vec,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [VEC_W-1:0]   req1_vec,
  output logic               req1_ready,
  output logic [CHUNK_W-1:0] lut_in,
  input  logic [CHUNK_W-1:0] lut_out,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [VEC_W-1:0]   resp_vec,
  output logic               resp_id,
  output logic               busy
);

  localparam int BEAT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                            state_q, state_d;
  logic [BEAT_W-1:0]                 beat_q, beat_d;
  logic                              prio_q, prio_d;
  logic                              id_q, id_d;
  // Vectors are held as beat-indexed slices so the current chunk is a plain array select.
  logic [NUM_BEATS-1:0][CHUNK_W-1:0] vec_q, vec_d;
  logic [NUM_BEATS-1:0][CHUNK_W-1:0] res_q, res_d;
  logic                              grant0, grant1;

  // Arbitration: a lone requester always wins; on contention prio_q picks (0 favours req0).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && (!req1_valid || !prio_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign resp_vec   = res_q;
  assign resp_id    = id_q;

  // Next-state logic: capture on accept, one LUT beat per RUN cycle, hold result in DONE.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    prio_d  = prio_q;
    id_d    = id_q;
    vec_d   = vec_q;
    res_d   = res_q;
    lut_in  = '0;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          vec_d   = req0_vec;
          id_d    = 1'b0;
          prio_d  = 1'b1;
          beat_d  = '0;
          state_d = RUN;
        end else if (grant1) begin
          vec_d   = req1_vec;
          id_d    = 1'b1;
          prio_d  = 1'b0;
          beat_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        lut_in        = vec_q[beat_q];
        res_d[beat_q] = lut_out;
        // The beat counter parks on the last beat; it is only cleared by the next accept.
        if (beat_q == LAST_BEAT) begin
          state_d = DONE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight job without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      vec_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: doc/lut_sched.md
Name: lut_sched

Overview:
- Shares one narrow, combinational byte-substitution LUT between two vector requesters in the Vec_CPU.
- Each requester submits a 128-bit vector.
- The block arbitrates round-robin, streams the vector through the LUT one CHUNK_W slice per cycle, and reassembles the substituted vector.
- It returns the result with the winning requester's id over a valid/ready response port.

Parameters:
- VEC_W, 128, vector width in bits; must be a multiple of CHUNK_W.
- CHUNK_W, 32, bits presented to the LUT per beat (4 bytes).
- NUM_BEATS, VEC_W/CHUNK_W (4), derived beat count; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a vector.
- req0_vec  in  VEC_W  requester 0 vector.
- req0_ready  out  1  requester 0 accepted this cycle (valid&ready).
- req1_valid  in  1  requester 1 has a vector.
- req1_vec  in  VEC_W  requester 1 vector.
- req1_ready  out  1  requester 1 accepted this cycle.
- lut_in  out  CHUNK_W  slice driven to the external LUT.
- lut_out  in  CHUNK_W  LUT result for lut_in, combinational, same cycle.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_vec  out  VEC_W  substituted vector.
- resp_id  out  1  requester that owns resp_vec.
- busy  out  1  high in RUN or DONE.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values (async, on rst_n low, including mid-operation): state=IDLE, beat=0, prio=0 (req0 favoured), resp_valid=0, resp_vec=0, resp_id=0, internal vector register=0. Any in-flight job is discarded with no response.
- IDLE arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the one selected by prio.
  - reqN_ready=1 only for the granted requester, combinationally, only in IDLE.
  - On the handshake: capture reqN_vec, set id=N, beat=0, prio=~N, go to RUN.
- RUN:
  - lut_in = captured_vec[beat*CHUNK_W +: CHUNK_W], lowest slice first.
  - Each cycle, lut_out is written into result[beat*CHUNK_W +: CHUNK_W] and beat increments.
  - After beat NUM_BEATS-1, go to DONE.
  - No wrap: beat returns to 0 only on the next accept.
- DONE:
  - resp_valid=1; resp_vec and resp_id are held stable until resp_ready.
  - On resp_valid&resp_ready, go to IDLE next cycle.
  - New requests are not accepted in the same cycle as the response (one bubble).
- lut_in = 0 outside RUN. Both readys = 0 in RUN and DONE.
- Latency: accept at edge T, LUT beats at cycles T+1..T+NUM_BEATS, resp_valid high from T+NUM_BEATS+1.
- Throughput: at most one vector per NUM_BEATS+2 cycles with resp_ready tied high.
- Request inputs are sampled only at accept. Changes to reqN_vec after accept have no effect.
- Back-to-back requests from the same requester with the other idle are all granted; prio only matters on contention.
- resp_ready low in DONE: stall indefinitely, outputs stable, no new grant.

Test Plan:
- Single request:
  - Stimulus: after reset, req0_valid=1, req0_vec=0x00112233_44556677_8899AABB_CCDDEEFF; bench LUT model = per-byte +1 mod 256.
  - Required: req0_ready=1 for one cycle.
  - Required: lut_in sequence 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233.
  - Required: resp_vec=0x01122334_45566778_899AABBC_CDDEEF00, resp_id=0, 5 cycles after accept.
- Contention:
  - Stimulus: req0 and req1 valid continuously from reset.
  - Required: grants alternate 0,1,0,1. resp_id sequence matches. The other ready stays 0 while busy.
- Backpressure:
  - Stimulus: resp_ready=0 for 10 cycles in DONE.
  - Required: resp_valid, resp_vec, resp_id stable; both readys 0; lut_in=0. The response completes on the first resp_ready=1, then IDLE.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 asynchronously at beat 2.
  - Required: outputs immediately 0, busy=0. After release, a pending req1 with req0 idle is granted and returns a correct result.
- Wrap value:
  - Stimulus: req1_vec all 0xFF with the +1 LUT model.
  - Required: resp_vec=0, resp_id=1.
- Late input change:
  - Stimulus: change req0_vec the cycle after accept.
  - Required: the result reflects the originally captured vector.
